// File: rtl/adder_error_monitor.sv
// adder_error_monitor: streaming error-distance monitor for approximate adders.
// Each accepted sample's exact sum is recomputed, |exact - result| is formed,
// and window statistics (saturating sum, nonzero count, optional max) are
// accumulated over 2^NSAMP_LOG2 samples.
// Optional build macro: ERR_MAX_TRACK_EN enables the window-maximum tracker;
// when undefined err_max_o is tied to zero.
module adder_error_monitor #(
   parameter int WIDTH      = 16,
   parameter int NSAMP_LOG2 = 10,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WIDTH-1:0]      add1_i,
   input  logic [WIDTH-1:0]      add2_i,
   input  logic [WIDTH:0]        result_i,
   output logic [WIDTH:0]        err_o,
   output logic                  err_valid_o,
   output logic [ACC_WIDTH-1:0]  err_sum_o,
   output logic [NSAMP_LOG2:0]   err_cnt_o,
   output logic [WIDTH:0]        err_max_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [NSAMP_LOG2-1:0]  samp_cnt;
   logic                   drain_cnt;
   logic                   xfer;
   logic                   win_start;
   logic                   last_xfer;

   logic                   s1_valid;
   logic [WIDTH:0]         s1_exact;
   logic [WIDTH:0]         s1_result;
   logic [WIDTH:0]         diff;
   logic [ACC_WIDTH:0]     sum_wide;
   logic                   err_nz;

   // Outputs are pure decodes of the state register, so ready_o never
   // depends on valid_i.
   assign ready_o   = (state == RUN);
   assign busy_o    = (state == RUN) || (state == DRAIN);
   assign done_o    = (state == DONE);

   assign xfer      = ready_o & valid_i;
   assign win_start = start_i & ((state == IDLE) || (state == DONE));
   assign last_xfer = xfer & (samp_cnt == '1);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: RUN until the last sample, two DRAIN cycles, then DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = RUN;
         RUN:     if (last_xfer) state_next = DRAIN;
         DRAIN:   if (drain_cnt) state_next = DONE;
         DONE:    if (start_i) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // Sample counter over the window; wraps to zero on the final transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         samp_cnt <= '0;
      end else if (win_start) begin
         samp_cnt <= '0;
      end else if (xfer) begin
         samp_cnt <= samp_cnt + 1'b1;
      end
   end

   // Drain timer: zero during the first DRAIN cycle, one during the second.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= (state == DRAIN);
      end
   end

   // Stage 1: capture the exact sum at full WIDTH+1 width and the DUT result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid  <= 1'b0;
         s1_exact  <= '0;
         s1_result <= '0;
      end else begin
         s1_valid <= xfer;
         if (xfer) begin
            s1_exact  <= {1'b0, add1_i} + {1'b0, add2_i};
            s1_result <= result_i;
         end
      end
   end

   // Absolute error distance between exact and approximate results.
   always_comb begin
      diff = '0;
      if (s1_exact >= s1_result) begin
         diff = s1_exact - s1_result;
      end else begin
         diff = s1_result - s1_exact;
      end
   end

   // Stage 2: publish the per-sample error with a one-cycle valid pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_valid_o <= 1'b0;
         err_o       <= '0;
      end else begin
         err_valid_o <= s1_valid;
         if (s1_valid) begin
            err_o <= diff;
         end
      end
   end

   // One extra bit on the adder exposes overflow for saturation.
   always_comb begin
      sum_wide = {1'b0, err_sum_o} + {{(ACC_WIDTH - WIDTH){1'b0}}, err_o};
      err_nz   = (err_o != '0);
   end

   // Stage 3: saturating error sum and nonzero-error count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_sum_o <= '0;
         err_cnt_o <= '0;
      end else if (win_start) begin
         err_sum_o <= '0;
         err_cnt_o <= '0;
      end else if (err_valid_o) begin
         err_sum_o <= sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
         err_cnt_o <= err_cnt_o + {{NSAMP_LOG2{1'b0}}, err_nz};
      end
   end

`ifdef ERR_MAX_TRACK_EN
   // Stage 3: running maximum of the error distance within the window.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_max_o <= '0;
      end else if (win_start) begin
         err_max_o <= '0;
      end else if (err_valid_o && (err_o > err_max_o)) begin
         err_max_o <= err_o;
      end
   end
`else
   assign err_max_o = '0;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: scoreboard bench for adder_error_monitor with a
// 4-sample window and a 17-bit accumulator so saturation is reachable.
// Driver pushes expected per-sample errors and window statistics into
// queues; a negedge monitor pops and compares when the DUT presents them.
module tb_adder_error_monitor;

   localparam int W  = 16;
   localparam int NL = 2;
   localparam int AW = 17;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            valid;
   logic            ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [W:0]      r;
   logic [W:0]      err;
   logic            err_valid;
   logic [AW-1:0]   err_sum;
   logic [NL:0]     err_cnt;
   logic [W:0]      err_max;
   logic            busy;
   logic            done;

   adder_error_monitor #(.WIDTH(W), .NSAMP_LOG2(NL), .ACC_WIDTH(AW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .valid_i     (valid),
      .ready_o     (ready),
      .add1_i      (a),
      .add2_i      (b),
      .result_i    (r),
      .err_o       (err),
      .err_valid_o (err_valid),
      .err_sum_o   (err_sum),
      .err_cnt_o   (err_cnt),
      .err_max_o   (err_max),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [16:0] r;
      logic [16:0] e;
   } vec_t;

   typedef struct {
      logic [16:0] sum;
      logic [2:0]  cnt;
      logic [16:0] mx;
      int          dcyc;
   } win_t;

   // Hand-computed vectors, four per window.
   vec_t tbl [16] = '{
      // window A: exact results
      '{16'h0001, 16'h0002, 17'h00003, 17'h00000},
      '{16'h1234, 16'h4321, 17'h05555, 17'h00000},
      '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 17'h00000},
      '{16'h8000, 16'h8000, 17'h10000, 17'h00000},
      // window B: result = exact - 3
      '{16'h0010, 16'h0020, 17'h0002D, 17'h00003},
      '{16'h1000, 16'h0003, 17'h01000, 17'h00003},
      '{16'hFFFF, 16'h0001, 17'h0FFFD, 17'h00003},
      '{16'h0000, 16'h0003, 17'h00000, 17'h00003},
      // window C: lost carry-out, result above exact, mixed
      '{16'hFFFF, 16'h0001, 17'h00000, 17'h10000},
      '{16'h0005, 16'h0005, 17'h0000F, 17'h00005},
      '{16'h0100, 16'h0000, 17'h00100, 17'h00000},
      '{16'h0000, 16'h0000, 17'h00007, 17'h00007},
      // window D: saturation of the 17-bit sum
      '{16'hFFFF, 16'h0001, 17'h00000, 17'h10000},
      '{16'h0000, 16'h0000, 17'h10000, 17'h10000},
      '{16'h0001, 16'h0001, 17'h00002, 17'h00000},
      '{16'h0002, 16'h0003, 17'h00004, 17'h00001}
   };

   logic [16:0] err_q [$];
   win_t        win_q [$];
   int          ncmp = 0;
   int          nerr = 0;

   function automatic logic [16:0] mx_exp(input logic [16:0] m);
`ifdef ERR_MAX_TRACK_EN
      return m;
`else
      return 17'h0 & m;
`endif
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: per-sample errors and end-of-window statistics.
   logic [16:0] mon_e;
   win_t        mon_w;
   logic        done_d = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         done_d <= 1'b0;
      end else begin
         if (err_valid) begin
            if (err_q.size() == 0) begin
               check("unexpected_err_valid", 32'd1, 32'd0);
            end else begin
               mon_e = err_q.pop_front();
               check("err_o", {15'd0, err}, {15'd0, mon_e});
            end
         end
         if (done && !done_d) begin
            if (win_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_w = win_q.pop_front();
               check("err_sum", {15'd0, err_sum}, {15'd0, mon_w.sum});
               check("err_cnt", {29'd0, err_cnt}, {29'd0, mon_w.cnt});
               check("err_max", {15'd0, err_max}, {15'd0, mon_w.mx});
               check("done_cycle", cyc, mon_w.dcyc);
            end
         end
         done_d <= done;
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v, input bit last, input win_t w);
      bit   ok;
      win_t ww;
      ok    = 1'b0;
      valid = 1'b1;
      a     = v.a;
      b     = v.b;
      r     = v.r;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = ready;
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      if (!ok) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         err_q.push_back(v.e);
         if (last) begin
            ww      = w;
            ww.dcyc = cyc + 2;
            win_q.push_back(ww);
            check("ready_drop_last", {31'd0, ready}, 32'd0);
         end
      end
   endtask

   task automatic do_start(input bit with_valid);
      start = 1'b1;
      if (with_valid) begin
         valid = 1'b1;
         a     = 16'hFFFF;
         b     = 16'hFFFF;
         r     = 17'h00000;
      end
      @(negedge clk);
      check("ready_during_start", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      valid = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic run_window(input int base, input bit gaps, input win_t w);
      for (int i = 0; i < 4; i++) begin
         send(tbl[base + i], (i == 3), w);
         if (gaps && i < 3) begin
            if (i == 1) start = 1'b1;
            idle_cycle();
            start = 1'b0;
            if (i == 1) check("ready_after_run_start", {31'd0, ready}, 32'd1);
         end
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      idle_cycle();
      idle_cycle();
      check("done_hold", {31'd0, done}, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},     {31'd0, ready},     32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_done"},      {31'd0, done},      32'd0);
      check({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
      check({tag, "_err"},       {15'd0, err},       32'd0);
      check({tag, "_err_sum"},   {15'd0, err_sum},   32'd0);
      check({tag, "_err_cnt"},   {29'd0, err_cnt},   32'd0);
      check({tag, "_err_max"},   {15'd0, err_max},   32'd0);
   endtask

   win_t w_a, w_b, w_c, w_d;

   initial begin
      w_a = '{sum: 17'h00000, cnt: 3'd0, mx: mx_exp(17'h00000), dcyc: 0};
      w_b = '{sum: 17'h0000C, cnt: 3'd4, mx: mx_exp(17'h00003), dcyc: 0};
      w_c = '{sum: 17'h1000C, cnt: 3'd3, mx: mx_exp(17'h10000), dcyc: 0};
      w_d = '{sum: 17'h1FFFF, cnt: 3'd3, mx: mx_exp(17'h10000), dcyc: 0};

      rst   = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      a     = '0;
      b     = '0;
      r     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      idle_cycle();

      do_start(1'b0);
      run_window(0, 1'b0, w_a);
      wait_done();

      // start coincident with a sample: that sample must not be consumed
      do_start(1'b1);
      run_window(4, 1'b1, w_b);
      wait_done();

      do_start(1'b0);
      run_window(8, 1'b0, w_c);
      wait_done();

      do_start(1'b0);
      run_window(12, 1'b0, w_d);
      wait_done();
      check("sat_held", {15'd0, err_sum}, 32'h1FFFF);

      // reset two samples into a window
      do_start(1'b0);
      send(tbl[8], 1'b0, w_c);
      send(tbl[9], 1'b0, w_c);
      repeat (3) idle_cycle();
      check("partial_sum", {15'd0, err_sum}, 32'h10005);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      idle_cycle();
      rst = 1'b0;
      idle_cycle();

      do_start(1'b0);
      run_window(0, 1'b0, w_a);
      wait_done();

      check("pending_err", err_q.size(), 32'd0);
      check("pending_win", win_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
